// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART byte transmitter among N_REQ requesters.
// A grant is held for a whole frame; a watchdog drops stuck transmitters and abandoned frames.
module uart_tx_arbiter #(
  parameter int N_REQ        = 4,
  parameter int DONE_TIMEOUT = 8192,
  parameter int LOCK_TIMEOUT = 65535,
  localparam int ID_W        = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic [ID_W-1:0]    grant_id,
  output logic               busy,
  output logic               err_timeout,
  output logic               tx_data_valid,
  output logic [7:0]         tx_data,
  input  logic               tx_done
);

  localparam int SUM_W  = ID_W + 1;
  localparam int WCNT_W = $clog2(DONE_TIMEOUT);
  localparam int LCNT_W = $clog2(LOCK_TIMEOUT + 1);

  localparam logic [WCNT_W-1:0] WAIT_MAX  = WCNT_W'(DONE_TIMEOUT - 1);
  localparam logic [WCNT_W-1:0] WAIT_TERM = WCNT_W'(DONE_TIMEOUT - 2);
  localparam logic [LCNT_W-1:0] LOCK_MAX  = LCNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [LCNT_W-1:0] LOCK_TERM = LCNT_W'(LOCK_TIMEOUT - 2);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, LOCK} state_t;

  state_t            state;
  logic [ID_W-1:0]   rr_ptr;
  logic              last_r;
  logic [WCNT_W-1:0] wait_cnt;
  logic [LCNT_W-1:0] lock_cnt;

  logic [ID_W-1:0]   pick;
  logic              pick_ok;
  logic [SUM_W-1:0]  sum;
  logic [ID_W-1:0]   idx;
  logic [ID_W-1:0]   issue_id;
  logic              go_issue;

  assign busy = (state != IDLE);

  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    return (id == ID_W'(N_REQ - 1)) ? '0 : id + ID_W'(1);
  endfunction

  // First valid requester at or after rr_ptr, wrapping at N_REQ.
  always_comb begin
    pick    = '0;
    pick_ok = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sum = {1'b0, rr_ptr} + SUM_W'(i);
      if (sum >= SUM_W'(N_REQ)) sum = sum - SUM_W'(N_REQ);
      idx = sum[ID_W-1:0];
      if (!pick_ok && req_valid[idx]) begin
        pick    = idx;
        pick_ok = 1'b1;
      end
    end
  end

  always_comb begin
    issue_id = (state == IDLE) ? pick : grant_id;
    go_issue = 1'b0;
    case (state)
      IDLE:    go_issue = pick_ok;
      WAIT:    go_issue = tx_done && !last_r && req_valid[grant_id];
      LOCK:    go_issue = req_valid[grant_id];
      default: go_issue = 1'b0;
    endcase
  end

  // Timeouts fire on the edge where a counter reaches its terminal value,
  // so the registered err_timeout pulse coincides with that count.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      grant_id      <= '0;
      last_r        <= 1'b0;
      wait_cnt      <= '0;
      lock_cnt      <= '0;
      req_ready     <= '0;
      err_timeout   <= 1'b0;
      tx_data_valid <= 1'b0;
      tx_data       <= '0;
    end else begin
      req_ready     <= '0;
      err_timeout   <= 1'b0;
      tx_data_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_ok) begin
            grant_id <= pick;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (tx_done) begin
            if (last_r) begin
              rr_ptr <= next_id(grant_id);
              state  <= IDLE;
            end else if (req_valid[grant_id]) begin
              state <= ISSUE;
            end else begin
              lock_cnt <= '0;
              state    <= LOCK;
            end
          end else if (wait_cnt == WAIT_TERM) begin
            wait_cnt    <= WAIT_MAX;
            err_timeout <= 1'b1;
            rr_ptr      <= next_id(grant_id);
            state       <= IDLE;
          end else if (wait_cnt != WAIT_MAX) begin
            wait_cnt <= wait_cnt + WCNT_W'(1);
          end
        end
        LOCK: begin
          if (req_valid[grant_id]) begin
            state <= ISSUE;
          end else if (lock_cnt == LOCK_TERM) begin
            lock_cnt    <= LOCK_MAX;
            err_timeout <= 1'b1;
            rr_ptr      <= next_id(grant_id);
            state       <= IDLE;
          end else if (lock_cnt != LOCK_MAX) begin
            lock_cnt <= lock_cnt + LCNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
      if (go_issue) begin
        tx_data_valid <= 1'b1;
        tx_data       <= req_data[{issue_id, 3'b000} +: 8];
        req_ready     <= N_REQ'(1) << issue_id;
        last_r        <= req_last[issue_id];
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: round robin, frame lock, watchdogs and async reset.
// Inputs are driven and outputs sampled on the falling edge of clk.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [1:0]  grant_id;
  logic        busy;
  logic        err_timeout;
  logic        tx_data_valid;
  logic [7:0]  tx_data;
  logic        tx_done;

  int n_cmp  = 0;
  int n_fail = 0;

  uart_tx_arbiter #(
    .N_REQ(4),
    .DONE_TIMEOUT(32),
    .LOCK_TIMEOUT(64)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_last(req_last),
    .req_ready(req_ready),
    .grant_id(grant_id),
    .busy(busy),
    .err_timeout(err_timeout),
    .tx_data_valid(tx_data_valid),
    .tx_data(tx_data),
    .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rstn = 1'b0; req_valid = '0; req_data = '0; req_last = '0; tx_done = 1'b0;
    tick(); tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rstn = 1'b0; req_valid = '0; req_data = '0; req_last = '0; tx_done = 1'b0;
    tick(); tick();
    n_cmp++; if (req_ready !== 4'b0)   begin n_fail++; $display("[TB] FAIL reset_ready: got %b want 0000", req_ready); end
    n_cmp++; if (grant_id !== 2'd0)    begin n_fail++; $display("[TB] FAIL reset_grant: got %0d want 0", grant_id); end
    n_cmp++; if (busy !== 1'b0)        begin n_fail++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (err_timeout !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_err: got %b want 0", err_timeout); end
    n_cmp++; if (tx_data_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid: got %b want 0", tx_data_valid); end
    n_cmp++; if (tx_data !== 8'h00)    begin n_fail++; $display("[TB] FAIL reset_data: got %h want 00", tx_data); end
    rstn = 1'b1;
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_release_busy: got %b want 0", busy); end
  endtask

  task automatic test_done_ignored();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL idle_done_busy: got %b want 0", busy); end
    n_cmp++; if (tx_data_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL idle_done_valid: got %b want 0", tx_data_valid); end
  endtask

  task automatic test_single_byte();
    req_data[7:0] = 8'h55; req_last[0] = 1'b1; req_valid[0] = 1'b1;
    tick();
    n_cmp++; if (tx_data_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL single_valid: got %b want 1", tx_data_valid); end
    n_cmp++; if (tx_data !== 8'h55)      begin n_fail++; $display("[TB] FAIL single_data: got %h want 55", tx_data); end
    n_cmp++; if (req_ready !== 4'b0001)  begin n_fail++; $display("[TB] FAIL single_ready: got %b want 0001", req_ready); end
    n_cmp++; if (busy !== 1'b1)          begin n_fail++; $display("[TB] FAIL single_busy_issue: got %b want 1", busy); end
    n_cmp++; if (grant_id !== 2'd0)      begin n_fail++; $display("[TB] FAIL single_grant: got %0d want 0", grant_id); end
    tick();
    req_valid[0] = 1'b0;
    n_cmp++; if (tx_data_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL single_valid_pulse: got %b want 0", tx_data_valid); end
    n_cmp++; if (req_ready !== 4'b0000)  begin n_fail++; $display("[TB] FAIL single_ready_pulse: got %b want 0000", req_ready); end
    for (int c = 3; c < 20; c++) tick();
    tick();
    tx_done = 1'b1;
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL single_busy_done: got %b want 1", busy); end
    tick();
    tx_done = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL single_busy_after: got %b want 0", busy); end
    n_cmp++; if (err_timeout !== 1'b0) begin n_fail++; $display("[TB] FAIL single_err: got %b want 0", err_timeout); end
  endtask

  task automatic test_rr_after_single();
    req_data[7:0] = 8'hB0; req_data[15:8] = 8'hB1; req_last[1:0] = 2'b11; req_valid[1:0] = 2'b11;
    tick();
    n_cmp++; if (grant_id !== 2'd1)     begin n_fail++; $display("[TB] FAIL rr1_grant: got %0d want 1", grant_id); end
    n_cmp++; if (tx_data !== 8'hB1)     begin n_fail++; $display("[TB] FAIL rr1_data: got %h want b1", tx_data); end
    n_cmp++; if (req_ready !== 4'b0010) begin n_fail++; $display("[TB] FAIL rr1_ready: got %b want 0010", req_ready); end
    tick();
    req_valid[1] = 1'b0;
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    tick();
    n_cmp++; if (grant_id !== 2'd0) begin n_fail++; $display("[TB] FAIL rr0_grant: got %0d want 0", grant_id); end
    n_cmp++; if (tx_data !== 8'hB0) begin n_fail++; $display("[TB] FAIL rr0_data: got %h want b0", tx_data); end
    tick();
    req_valid[0] = 1'b0;
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    tick();
  endtask

  task automatic test_round_robin_all();
    for (int k = 0; k < 4; k++) req_data[8*k +: 8] = 8'hA0 + 8'(k);
    req_last = 4'b1111; req_valid = 4'b1111;
    tick();
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (tx_data_valid !== 1'b1)   begin n_fail++; $display("[TB] FAIL rrall_valid[%0d]: got %b want 1", k, tx_data_valid); end
      n_cmp++; if (tx_data !== 8'hA0 + 8'(k)) begin n_fail++; $display("[TB] FAIL rrall_data[%0d]: got %h want %h", k, tx_data, 8'hA0 + 8'(k)); end
      n_cmp++; if (grant_id !== 2'(k))        begin n_fail++; $display("[TB] FAIL rrall_grant[%0d]: got %0d want %0d", k, grant_id, k); end
      n_cmp++; if (req_ready !== 4'(1 << k))  begin n_fail++; $display("[TB] FAIL rrall_ready[%0d]: got %b want %b", k, req_ready, 4'(1 << k)); end
      tick();
      req_valid[k] = 1'b0;
      tick(); tick();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      n_cmp++; if (tx_data_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rrall_gap_valid[%0d]: got %b want 0", k, tx_data_valid); end
      n_cmp++; if (busy !== 1'b0)          begin n_fail++; $display("[TB] FAIL rrall_gap_busy[%0d]: got %b want 0", k, busy); end
      tick();
    end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL rrall_end_busy: got %b want 0", busy); end
  endtask

  task automatic test_frame_lock();
    logic [7:0] bytes [3];
    bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33;
    req_data[23:16] = bytes[0]; req_last[2] = 1'b0; req_valid[2] = 1'b1;
    tick();
    for (int j = 0; j < 3; j++) begin
      n_cmp++; if (tx_data_valid !== 1'b1)  begin n_fail++; $display("[TB] FAIL lock_valid[%0d]: got %b want 1", j, tx_data_valid); end
      n_cmp++; if (tx_data !== bytes[j])    begin n_fail++; $display("[TB] FAIL lock_data[%0d]: got %h want %h", j, tx_data, bytes[j]); end
      n_cmp++; if (grant_id !== 2'd2)       begin n_fail++; $display("[TB] FAIL lock_grant[%0d]: got %0d want 2", j, grant_id); end
      n_cmp++; if (req_ready !== 4'b0100)   begin n_fail++; $display("[TB] FAIL lock_ready[%0d]: got %b want 0100", j, req_ready); end
      if (j == 0) begin
        req_data[15:8] = 8'hC1; req_last[1] = 1'b1; req_valid[1] = 1'b1;
      end
      tick();
      if (j < 2) begin
        req_data[23:16] = bytes[j+1];
        req_last[2] = (j == 1);
      end else begin
        req_valid[2] = 1'b0;
      end
      n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("[TB] FAIL lock_blocked[%0d]: got %b want 0000", j, req_ready); end
      tick();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
    end
    n_cmp++; if (busy !== 1'b0)          begin n_fail++; $display("[TB] FAIL lock_release_busy: got %b want 0", busy); end
    n_cmp++; if (tx_data_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL lock_release_valid: got %b want 0", tx_data_valid); end
    tick();
    n_cmp++; if (grant_id !== 2'd1)      begin n_fail++; $display("[TB] FAIL lock_next_grant: got %0d want 1", grant_id); end
    n_cmp++; if (tx_data !== 8'hC1)      begin n_fail++; $display("[TB] FAIL lock_next_data: got %h want c1", tx_data); end
    n_cmp++; if (req_ready !== 4'b0010)  begin n_fail++; $display("[TB] FAIL lock_next_ready: got %b want 0010", req_ready); end
    tick();
    req_valid[1] = 1'b0;
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  task automatic test_lock_timeout();
    req_data[15:8] = 8'h44; req_last[1] = 1'b0; req_valid[1] = 1'b1;
    tick();
    n_cmp++; if (grant_id !== 2'd1) begin n_fail++; $display("[TB] FAIL lto_grant: got %0d want 1", grant_id); end
    n_cmp++; if (tx_data !== 8'h44) begin n_fail++; $display("[TB] FAIL lto_data: got %h want 44", tx_data); end
    req_data[31:24] = 8'h77; req_last[3] = 1'b1; req_valid[3] = 1'b1;
    tick();
    req_valid[1] = 1'b0;
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL lto_lock_busy: got %b want 1", busy); end
    for (int c = 1; c < 63; c++) begin
      tick();
      n_cmp++; if (err_timeout !== 1'b0) begin n_fail++; $display("[TB] FAIL lto_early_err[%0d]: got %b want 0", c, err_timeout); end
      n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("[TB] FAIL lto_blocked[%0d]: got %b want 0000", c, req_ready); end
    end
    tick();
    n_cmp++; if (err_timeout !== 1'b1) begin n_fail++; $display("[TB] FAIL lto_err: got %b want 1", err_timeout); end
    n_cmp++; if (busy !== 1'b0)        begin n_fail++; $display("[TB] FAIL lto_idle: got %b want 0", busy); end
    tick();
    n_cmp++; if (err_timeout !== 1'b0)   begin n_fail++; $display("[TB] FAIL lto_err_pulse: got %b want 0", err_timeout); end
    n_cmp++; if (tx_data_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL lto_next_valid: got %b want 1", tx_data_valid); end
    n_cmp++; if (grant_id !== 2'd3)      begin n_fail++; $display("[TB] FAIL lto_next_grant: got %0d want 3", grant_id); end
    n_cmp++; if (tx_data !== 8'h77)      begin n_fail++; $display("[TB] FAIL lto_next_data: got %h want 77", tx_data); end
    n_cmp++; if (req_ready !== 4'b1000)  begin n_fail++; $display("[TB] FAIL lto_next_ready: got %b want 1000", req_ready); end
    tick();
    req_valid[3] = 1'b0;
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  task automatic test_done_timeout();
    req_data[7:0] = 8'h99; req_last[0] = 1'b1; req_valid[0] = 1'b1;
    tick();
    n_cmp++; if (tx_data !== 8'h99) begin n_fail++; $display("[TB] FAIL dto_data: got %h want 99", tx_data); end
    n_cmp++; if (grant_id !== 2'd0) begin n_fail++; $display("[TB] FAIL dto_grant: got %0d want 0", grant_id); end
    tick();
    req_valid[0] = 1'b0;
    for (int c = 2; c < 32; c++) begin
      tick();
      n_cmp++; if (err_timeout !== 1'b0)   begin n_fail++; $display("[TB] FAIL dto_early_err[%0d]: got %b want 0", c, err_timeout); end
      n_cmp++; if (tx_data_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL dto_stray_valid[%0d]: got %b want 0", c, tx_data_valid); end
    end
    tick();
    n_cmp++; if (err_timeout !== 1'b1)   begin n_fail++; $display("[TB] FAIL dto_err: got %b want 1", err_timeout); end
    n_cmp++; if (busy !== 1'b0)          begin n_fail++; $display("[TB] FAIL dto_idle: got %b want 0", busy); end
    n_cmp++; if (tx_data_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL dto_valid: got %b want 0", tx_data_valid); end
    req_data[7:0] = 8'h9A; req_data[15:8] = 8'h9B; req_last[1:0] = 2'b11; req_valid[1:0] = 2'b11;
    tick();
    n_cmp++; if (err_timeout !== 1'b0) begin n_fail++; $display("[TB] FAIL dto_err_pulse: got %b want 0", err_timeout); end
    n_cmp++; if (grant_id !== 2'd1)    begin n_fail++; $display("[TB] FAIL dto_rr_grant: got %0d want 1", grant_id); end
    n_cmp++; if (tx_data !== 8'h9B)    begin n_fail++; $display("[TB] FAIL dto_rr_data: got %h want 9b", tx_data); end
    tick();
    req_valid = '0;
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_frame();
    req_data[7:0] = 8'hD0; req_last[0] = 1'b0; req_valid[0] = 1'b1;
    tick();
    n_cmp++; if (tx_data !== 8'hD0) begin n_fail++; $display("[TB] FAIL mid_first_data: got %h want d0", tx_data); end
    tick();
    req_data[7:0] = 8'hD1;
    tick();
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_wait_busy: got %b want 1", busy); end
    #2 rstn = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0)          begin n_fail++; $display("[TB] FAIL mid_rst_busy: got %b want 0", busy); end
    n_cmp++; if (grant_id !== 2'd0)      begin n_fail++; $display("[TB] FAIL mid_rst_grant: got %0d want 0", grant_id); end
    n_cmp++; if (tx_data !== 8'h00)      begin n_fail++; $display("[TB] FAIL mid_rst_data: got %h want 00", tx_data); end
    n_cmp++; if (req_ready !== 4'b0000)  begin n_fail++; $display("[TB] FAIL mid_rst_ready: got %b want 0000", req_ready); end
    n_cmp++; if (tx_data_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_rst_valid: got %b want 0", tx_data_valid); end
    tick();
    rstn = 1'b1;
    req_data[7:0] = 8'hE0; req_data[23:16] = 8'hE2; req_last = 4'b0101; req_valid = 4'b0101;
    n_cmp++; if (tx_data_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_release_valid: got %b want 0", tx_data_valid); end
    tick();
    n_cmp++; if (tx_data_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_fresh_valid: got %b want 1", tx_data_valid); end
    n_cmp++; if (tx_data !== 8'hE0)      begin n_fail++; $display("[TB] FAIL mid_fresh_data: got %h want e0", tx_data); end
    n_cmp++; if (grant_id !== 2'd0)      begin n_fail++; $display("[TB] FAIL mid_fresh_grant: got %0d want 0", grant_id); end
    n_cmp++; if (req_ready !== 4'b0001)  begin n_fail++; $display("[TB] FAIL mid_fresh_ready: got %b want 0001", req_ready); end
    tick();
    req_valid[0] = 1'b0;
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    req_valid = '0;
    tick(); tick();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_done_ignored();
    test_single_byte();
    test_rr_after_single();
    do_reset();
    test_round_robin_all();
    test_frame_lock();
    test_lock_timeout();
    test_done_timeout();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
